alu_cmd_sequencer: RTL

- Initiator-side driver for the 8-bit registered ALU: accepts one operation at a time over a valid/ready command interface and drives A/B/opcode into the ALU.
- Waits the ALU pipeline latency, captures ALU_Out, and returns the result over a valid/ready response interface.
- Replaces hand-sequenced testbench stimulus with a synthesizable front end usable by a controller or bench.

---
 rtl/alu_cmd_sequencer_if.sv | 37 +++
 rtl/alu_cmd_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// master = command initiator + ALU + response consumer; slave = the sequencer.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_opcode;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_out;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_opcode;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_out,
        input  rsp_valid, rsp_data, rsp_opcode,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_out,
        output rsp_valid, rsp_data, rsp_opcode,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Front end for a registered 8-bit ALU: accepts one command, waits out the ALU
// pipeline, captures ALU_Out and presents it on a valid/ready response port.
//
// state  | meaning
// S_IDLE | ready for a command, ALU operands hold their last values
// S_WAIT | operands applied, counting down the ALU pipeline latency
// S_RESP | result held on rsp_* until the consumer takes it
module alu_cmd_sequencer #(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic [CNT_W-1:0]     op_count
);

    localparam int WAIT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;
    logic               cmd_ready_q,  cmd_ready_d;
    logic [7:0]         alu_a_q,      alu_a_d;
    logic [7:0]         alu_b_q,      alu_b_d;
    logic [3:0]         alu_opcode_q, alu_opcode_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic [7:0]         rsp_data_q,   rsp_data_d;
    logic [3:0]         rsp_opcode_q, rsp_opcode_d;
    logic [CNT_W-1:0]   op_count_q,   op_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            cmd_ready_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_opcode_q <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_opcode_q <= rsp_opcode_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_opcode_d = rsp_opcode_q;
        op_count_d   = op_count_q;

        case (state_q)
            S_IDLE: begin
                // cmd_ready_q is low only on the first cycle out of reset
                if (bus.cmd_valid && cmd_ready_q) begin
                    alu_a_d      = bus.cmd_a;
                    alu_b_d      = bus.cmd_b;
                    alu_opcode_d = bus.cmd_opcode;
                    rsp_opcode_d = bus.cmd_opcode;
                    wait_cnt_d   = WAIT_W'(ALU_LATENCY);
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_data_d  = bus.alu_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Registered ready that tracks the next state keeps it disjoint from rsp_valid
        cmd_ready_d = (state_d == S_IDLE);
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_opcode = rsp_opcode_q;
    assign op_count       = op_count_q;

endmodule
